// File: rtl/matrix_stream_loader.sv
// Dibit-stream loader for two DIM x DIM matrices (A then B) with a
// registered row/column read port for the compute block.
module matrix_stream_loader #(
    parameter int DIM         = 32,
    parameter int ELEM_W      = 8,
    parameter int B_TRANSPOSE = 1,
    parameter int ADDR_W      = $clog2(DIM)
) (
    input  logic                    clk_in,
    input  logic                    rst_in_n,
    input  logic                    load_start,
    input  logic                    axiiv,
    input  logic [1:0]              axiid,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       requested_a_row,
    input  logic [ADDR_W-1:0]       requested_b_col,
    output logic [DIM*ELEM_W-1:0]   a_row_out,
    output logic [DIM*ELEM_W-1:0]   b_col_out,
    output logic [ADDR_W-1:0]       a_addr_out,
    output logic [ADDR_W-1:0]       b_addr_out,
    output logic                    rd_valid,
    output logic                    complete,
    output logic                    loading,
    output logic                    overflow
);

    localparam int DPE = ELEM_W / 2;
    localparam int DCW = (DPE > 1) ? $clog2(DPE) : 1;
    localparam int RW  = DIM * ELEM_W;

    localparam logic [DCW-1:0]    DC_LAST = DCW'(DPE - 1);
    localparam logic [ADDR_W-1:0] IX_LAST = ADDR_W'(DIM - 1);
    localparam logic [ADDR_W:0]   DIM_X   = (ADDR_W + 1)'(DIM);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DCW-1:0]    dibit_q, dibit_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic              complete_q, complete_d;
    logic              loading_q, loading_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic [RW-1:0]     a_row_q, a_row_d;
    logic [RW-1:0]     b_col_q, b_col_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;

    logic              a_we, b_we;
    logic [ELEM_W-1:0] elem_sh;
    logic [ADDR_W-1:0] b_wrow, b_woff;

    logic [RW-1:0] a_mem_q [DIM];
    logic [RW-1:0] b_mem_q [DIM];

    // New dibit enters at the bottom; after DPE shifts the first one is on top
    assign elem_sh = (elem_q << 2) | ELEM_W'(axiid);

    always_comb begin
        state_d    = state_q;
        dibit_d    = dibit_q;
        col_d      = col_q;
        row_d      = row_q;
        elem_d     = elem_q;
        overflow_d = overflow_q;
        complete_d = (state_q == DONE);
        a_we       = 1'b0;
        b_we       = 1'b0;

        if (load_start) begin
            state_d    = LOAD_A;
            dibit_d    = '0;
            col_d      = '0;
            row_d      = '0;
            overflow_d = 1'b0;
            complete_d = 1'b0;
        end else if (axiiv && state_q != DONE) begin
            elem_d = elem_sh;
            if (dibit_q == DC_LAST) begin
                dibit_d = '0;
                a_we    = rst_in_n && (state_q == LOAD_A);
                b_we    = rst_in_n && (state_q == LOAD_B);
                if (col_q == IX_LAST) begin
                    col_d = '0;
                    if (row_q == IX_LAST) begin
                        row_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : DONE;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end else begin
                    col_d = col_q + ADDR_W'(1);
                end
            end else begin
                dibit_d = dibit_q + DCW'(1);
            end
        end else if (axiiv) begin
            overflow_d = 1'b1;
        end

        loading_d = (state_d != DONE);
    end

    always_comb begin
        if (B_TRANSPOSE != 0) begin
            b_wrow = col_q;
            b_woff = row_q;
        end else begin
            b_wrow = row_q;
            b_woff = col_q;
        end
    end

    // Read port: indices beyond DIM return zeros, echo stays raw
    always_comb begin
        a_row_d    = a_row_q;
        b_col_d    = b_col_q;
        a_addr_d   = a_addr_q;
        b_addr_d   = b_addr_q;
        rd_valid_d = rd_req & complete_q;
        if (rd_req) begin
            a_addr_d = requested_a_row;
            b_addr_d = requested_b_col;
            a_row_d  = ({1'b0, requested_a_row} < DIM_X) ?
                       a_mem_q[requested_a_row] : '0;
            b_col_d  = ({1'b0, requested_b_col} < DIM_X) ?
                       b_mem_q[requested_b_col] : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q    <= LOAD_A;
            dibit_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            elem_q     <= '0;
            complete_q <= 1'b0;
            loading_q  <= 1'b0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            a_row_q    <= '0;
            b_col_q    <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            dibit_q    <= dibit_d;
            col_q      <= col_d;
            row_q      <= row_d;
            elem_q     <= elem_d;
            complete_q <= complete_d;
            loading_q  <= loading_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            a_row_q    <= a_row_d;
            b_col_q    <= b_col_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (a_we) a_mem_q[row_q][col_q*ELEM_W +: ELEM_W] <= elem_sh;
        if (b_we) b_mem_q[b_wrow][b_woff*ELEM_W +: ELEM_W] <= elem_sh;
    end

    assign a_row_out  = a_row_q;
    assign b_col_out  = b_col_q;
    assign a_addr_out = a_addr_q;
    assign b_addr_out = b_addr_q;
    assign rd_valid   = rd_valid_q;
    assign complete   = complete_q;
    assign loading    = loading_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: two instances (6x6x8 transposed B,
// 4x4x6 row-major B) checked against a matrix-level model via scoreboard.
module tb_matrix_stream_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ls [2];
    logic       vv [2];
    logic       rq [2];
    logic [1:0] dd [2];
    logic [2:0] ra [2];
    logic [2:0] rb [2];

    logic [47:0] arow [2];
    logic [47:0] bcol [2];
    logic [2:0]  aa [2];
    logic [2:0]  ba [2];
    logic        rv [2];
    logic        cmp [2];
    logic        ld [2];
    logic        ov [2];

    logic [47:0] a0, b0;
    logic [23:0] a1, b1;
    logic [2:0]  aa0, ba0;
    logic [1:0]  aa1, ba1;

    assign arow[0] = a0;
    assign bcol[0] = b0;
    assign arow[1] = {24'b0, a1};
    assign bcol[1] = {24'b0, b1};
    assign aa[0]   = aa0;
    assign ba[0]   = ba0;
    assign aa[1]   = {1'b0, aa1};
    assign ba[1]   = {1'b0, ba1};

    matrix_stream_loader #(.DIM(6), .ELEM_W(8), .B_TRANSPOSE(1)) u_dut0 (
        .clk_in(clk), .rst_in_n(rst_n), .load_start(ls[0]),
        .axiiv(vv[0]), .axiid(dd[0]), .rd_req(rq[0]),
        .requested_a_row(ra[0]), .requested_b_col(rb[0]),
        .a_row_out(a0), .b_col_out(b0), .a_addr_out(aa0), .b_addr_out(ba0),
        .rd_valid(rv[0]), .complete(cmp[0]), .loading(ld[0]),
        .overflow(ov[0])
    );

    matrix_stream_loader #(.DIM(4), .ELEM_W(6), .B_TRANSPOSE(0)) u_dut1 (
        .clk_in(clk), .rst_in_n(rst_n), .load_start(ls[1]),
        .axiiv(vv[1]), .axiid(dd[1]), .rd_req(rq[1]),
        .requested_a_row(ra[1][1:0]), .requested_b_col(rb[1][1:0]),
        .a_row_out(a1), .b_col_out(b1), .a_addr_out(aa1), .b_addr_out(ba1),
        .rd_valid(rv[1]), .complete(cmp[1]), .loading(ld[1]),
        .overflow(ov[1])
    );

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
        logic [2:0]  ia;
        logic [2:0]  ib;
        logic        v;
        logic        chk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last [2];
    bit   known [2];
    bit   exp_cmp [2];

    int a_m [2][6][6];
    int b_m [2][6][6];
    int na [6][6];
    int nb [6][6];

    int tests = 0;
    int fails = 0;

    function automatic int dimk(int k); return k ? 4 : 6; endfunction
    function automatic int wk(int k);   return k ? 6 : 8; endfunction
    function automatic int tk(int k);   return k ? 0 : 1; endfunction
    function automatic int awk(int k);  return k ? 2 : 3; endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected row vector from the matrix model
    function automatic logic [47:0] row_exp(int k, int idx, bit isb);
        logic [47:0] r = '0;
        int d = dimk(k);
        int w = wk(k);
        int e;
        if (idx >= d) return r;
        for (int j = 0; j < d; j++) begin
            if (!isb) e = a_m[k][idx][j];
            else if (tk(k) == 1) e = b_m[k][j][idx];
            else e = b_m[k][idx][j];
            for (int bt = 0; bt < w; bt++) r[j*w+bt] = e[bt];
        end
        return r;
    endfunction

    task automatic issue(int k, int ia, int ib);
        exp_t e;
        @(negedge clk);
        rq[k] = 1'b1;
        ra[k] = 3'(ia);
        rb[k] = 3'(ib);
        e.a   = row_exp(k, ia, 1'b0);
        e.b   = row_exp(k, ib, 1'b1);
        e.ia  = 3'(ia);
        e.ib  = 3'(ib);
        e.v   = exp_cmp[k];
        e.chk = exp_cmp[k];
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic reads(int k, int n);
        int top = (1 << awk(k)) - 1;
        for (int i = 0; i < n; i++)
            issue(k, $urandom_range(0, top), $urandom_range(0, top));
        @(negedge clk);
        rq[k] = 1'b0;
    endtask

    // pat: 0 random, 1 A=I/B=2I, 2 A random / B(r,c)=0x10*r+c
    task automatic load(int k, int mode, int pat, bit pulse, int abort_at);
        int d = dimk(k);
        int w = wk(k);
        int dpe = w / 2;
        int total = 2 * d * d * dpe;
        int n = 0;
        int el;
        int gap;
        if (pulse) begin
            @(negedge clk);
            ls[k] = 1'b1;
            vv[k] = 1'($urandom);
            dd[k] = 2'($urandom);
            exp_cmp[k] = 1'b0;
            @(negedge clk);
            ls[k] = 1'b0;
            vv[k] = 1'b0;
            chk($sformatf("start_cmp%0d", k), cmp[k], 0);
            chk($sformatf("start_ld%0d", k), ld[k], 1);
            chk($sformatf("start_ov%0d", k), ov[k], 0);
        end
        for (int r = 0; r < d; r++)
            for (int c = 0; c < d; c++) begin
                case (pat)
                    1: begin
                        na[r][c] = (r == c) ? 1 : 0;
                        nb[r][c] = (r == c) ? 2 : 0;
                    end
                    2: begin
                        na[r][c] = int'($urandom_range(0, (1 << w) - 1));
                        nb[r][c] = 16 * r + c;
                    end
                    default: begin
                        na[r][c] = int'($urandom_range(0, (1 << w) - 1));
                        nb[r][c] = int'($urandom_range(0, (1 << w) - 1));
                    end
                endcase
            end
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < d; r++)
                for (int c = 0; c < d; c++) begin
                    el = m ? nb[r][c] : na[r][c];
                    for (int t = dpe - 1; t >= 0; t--) begin
                        if (n == abort_at) begin
                            vv[k] = 1'b0;
                            return;
                        end
                        gap = (n == 0) ? 0 : (mode == 1) ? 1 :
                              (mode == 2) ? $urandom_range(0, 2) : 0;
                        for (int g = 0; g < gap; g++) begin
                            @(negedge clk);
                            vv[k] = 1'b0;
                            dd[k] = 2'($urandom);
                        end
                        @(negedge clk);
                        if (n == total - 1) begin
                            chk($sformatf("pre_cmp%0d", k), cmp[k], 0);
                            chk($sformatf("pre_ld%0d", k), ld[k], 1);
                        end
                        vv[k] = 1'b1;
                        dd[k] = 2'((el >> (2 * t)) & 3);
                        n++;
                    end
                end
        @(negedge clk);
        vv[k] = 1'b0;
        chk($sformatf("done_cmp%0d", k), cmp[k], 0);
        chk($sformatf("done_ld%0d", k), ld[k], 0);
        @(negedge clk);
        chk($sformatf("cmp_rise%0d", k), cmp[k], 1);
        chk($sformatf("cmp_ov%0d", k), ov[k], 0);
        for (int r = 0; r < d; r++)
            for (int c = 0; c < d; c++) begin
                a_m[k][r][c] = na[r][c];
                b_m[k][r][c] = nb[r][c];
            end
        exp_cmp[k] = 1'b1;
    endtask

    task automatic extra(int k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vv[k] = 1'b1;
            dd[k] = 2'($urandom);
        end
        @(negedge clk);
        vv[k] = 1'b0;
        chk($sformatf("ovf_set%0d", k), ov[k], 1);
        chk($sformatf("ovf_cmp%0d", k), cmp[k], 1);
        chk($sformatf("ovf_ld%0d", k), ld[k], 0);
    endtask

    task automatic zero_chk();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("z_cmp%0d", k), cmp[k], 0);
            chk($sformatf("z_ld%0d", k), ld[k], 0);
            chk($sformatf("z_ov%0d", k), ov[k], 0);
            chk($sformatf("z_rv%0d", k), rv[k], 0);
            chk($sformatf("z_aa%0d", k), aa[k], 0);
            chk($sformatf("z_ba%0d", k), ba[k], 0);
            chk($sformatf("z_arow%0d", k), arow[k], 0);
            chk($sformatf("z_bcol%0d", k), bcol[k], 0);
        end
    endtask

    // Monitor: request sampled at a posedge is answered by the next negedge
    logic pend [2] = '{1'b0, 1'b0};
    logic rstp = 1'b1;

    always @(posedge clk) begin
        rstp    <= !rst_n;
        pend[0] <= rq[0] && rst_n;
        pend[1] <= rq[1] && rst_n;
    end

    task automatic mon(int k);
        exp_t e;
        bit got = 1'b0;
        if (rstp) begin
            last[k]  = '{default: '0};
            known[k] = 1'b1;
            return;
        end
        if (pend[k]) begin
            if (k == 0 && q0.size() > 0) begin
                e = q0.pop_front();
                got = 1'b1;
            end else if (k == 1 && q1.size() > 0) begin
                e = q1.pop_front();
                got = 1'b1;
            end
            chk($sformatf("sb_have%0d", k), got, 1);
            if (!got) return;
            chk($sformatf("rd_valid%0d", k), rv[k], e.v);
            chk($sformatf("rd_aaddr%0d", k), aa[k], e.ia);
            chk($sformatf("rd_baddr%0d", k), ba[k], e.ib);
            if (e.chk) begin
                chk($sformatf("rd_arow%0d", k), arow[k], e.a);
                chk($sformatf("rd_bcol%0d", k), bcol[k], e.b);
            end
            last[k]  = e;
            known[k] = e.chk;
        end else begin
            chk($sformatf("idle_valid%0d", k), rv[k], 0);
            chk($sformatf("hold_aaddr%0d", k), aa[k], last[k].ia);
            chk($sformatf("hold_baddr%0d", k), ba[k], last[k].ib);
            if (known[k]) begin
                chk($sformatf("hold_arow%0d", k), arow[k], last[k].a);
                chk($sformatf("hold_bcol%0d", k), bcol[k], last[k].b);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            ls[k] = 1'b0; vv[k] = 1'b0; rq[k] = 1'b0;
            dd[k] = 2'b0; ra[k] = 3'b0; rb[k] = 3'b0;
            exp_cmp[k] = 1'b0;
            known[k] = 1'b0;
            last[k] = '{default: '0};
        end
        repeat (2) @(negedge clk);
        zero_chk();
        rst_n = 1'b1;

        issue(0, 1, 2);
        @(negedge clk);
        rq[0] = 1'b0;

        for (int k = 0; k < 2; k++) begin
            load(k, 0, 0, 1'b0, -1);
            reads(k, 20);
            load(k, 1, 0, 1'b1, -1);
            reads(k, 12);
            extra(k);
            reads(k, 12);
            load(k, 2, 0, 1'b1, dimk(k) * dimk(k) * wk(k) / 2 + 5);
            issue(k, 0, 1);
            @(negedge clk);
            rq[k] = 1'b0;
            load(k, 2, 0, 1'b1, -1);
            reads(k, 16);
        end

        load(0, 0, 1, 1'b1, -1);
        issue(0, 3, 3);
        @(negedge clk);
        rq[0] = 1'b0;
        chk("ident_a", arow[0], 48'h0000_0100_0000);
        chk("ident_b", bcol[0], 48'h0000_0200_0000);
        chk("ident_v", rv[0], 1);

        load(1, 0, 2, 1'b1, -1);
        issue(1, 2, 2);
        @(negedge clk);
        rq[1] = 1'b0;
        chk("brow_b", bcol[1], {24'b0, 6'h23, 6'h22, 6'h21, 6'h20});
        load(0, 0, 2, 1'b1, -1);
        issue(0, 2, 2);
        @(negedge clk);
        rq[0] = 1'b0;
        chk("bcol_b", bcol[0], 48'h52_42_32_22_12_02);

        load(0, 0, 0, 1'b1, 30);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cmp[0] = 1'b0;
        exp_cmp[1] = 1'b0;
        zero_chk();
        issue(0, 1, 1);
        @(negedge clk);
        rq[0] = 1'b0;
        chk("rst_ld0", ld[0], 1);
        chk("rst_ld1", ld[1], 1);
        load(0, 2, 0, 1'b0, -1);
        load(1, 0, 0, 1'b0, -1);
        reads(0, 16);
        reads(1, 16);

        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(q0.size() + q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
